csr_regfile: RTL

- Machine-mode CSR storage, directly downstream of the CSR ALU.
- Supplies the current CSR value to the CSR ALU's csr operand.
- Commits the ALU result on the next rising clock edge.
- Owns the trap/mret state update, interrupt gating and the 64-bit cycle/instret counters for the single-cycle RV32 core.

---
 rtl/csr_pkg.sv | 28 ++
 rtl/csr_counter64.sv | 41 ++++
 rtl/csr_regfile.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared CSR addresses, bit positions and cause codes for the machine-mode CSR file.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIP_MEIP     = 11;

    localparam logic [31:0] CAUSE_MEXT_IRQ = 32'h8000_000B;

    function automatic logic csr_is_ro(input logic [11:0] addr);
        return (addr == CSR_MIP) || (addr == CSR_MHARTID);
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with independently writable halves (mcycle/minstret).
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] q
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [32:0] lo_sum;

    always_comb begin
        lo_sum = {1'b0, lo_q} + {32'd0, inc};
        lo_d   = lo_sum[31:0];
        hi_d   = hi_q + {31'd0, lo_sum[32]};
        // a write to either half swallows the carry for this edge
        if (wr_lo) begin
            lo_d = wdata;
            hi_d = hi_q;
        end else if (wr_hi) begin
            hi_d = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign q = {hi_q, lo_q};

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: storage, trap/mret update, interrupt gating.
// Counters are built only when CSR_COUNTERS_EN is defined.
module csr_regfile
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic        csr_re,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        illegal_csr,
    input  logic        trap_en,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret,
    input  logic        instret,
    input  logic        irq_ext,
    output logic        irq_take,
    output logic [31:0] trap_vector,
    output logic [31:0] epc
);

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic        meie_q, meie_d;
    logic        meip_q, meip_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] rdata;
    logic        implemented;
    logic        wr_en;

`ifdef CSR_COUNTERS_EN
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    csr_counter64 u_cycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (wr_en && csr_addr == CSR_MCYCLE),
        .wr_hi (wr_en && csr_addr == CSR_MCYCLEH),
        .wdata (csr_wdata),
        .q     (cycle_cnt)
    );

    csr_counter64 u_instret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instret),
        .wr_lo (wr_en && csr_addr == CSR_MINSTRET),
        .wr_hi (wr_en && csr_addr == CSR_MINSTRETH),
        .wdata (csr_wdata),
        .q     (instret_cnt)
    );
`else
    logic unused_instret;
    assign unused_instret = instret;
`endif

    always_comb begin
        rdata       = '0;
        implemented = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:   rdata = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
            CSR_MIE:       rdata = {20'd0, meie_q, 11'd0};
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MIP:       rdata = {20'd0, meip_q, 11'd0};
            CSR_MHARTID:   rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    rdata = cycle_cnt[31:0];
            CSR_MCYCLEH:   rdata = cycle_cnt[63:32];
            CSR_MINSTRET:  rdata = instret_cnt[31:0];
            CSR_MINSTRETH: rdata = instret_cnt[63:32];
`endif
            default:       implemented = 1'b0;
        endcase
    end

    assign csr_rdata   = rdata;
    assign illegal_csr = ((csr_re || csr_we) && !implemented)
                       || (csr_we && csr_is_ro(csr_addr));
    assign wr_en       = csr_we && !illegal_csr && !trap_en;

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        meip_d     = irq_ext;
        if (trap_en) begin
            mepc_d   = {trap_pc[31:2], 2'b00};
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else begin
            if (mret) begin
                mie_d  = mpie_q;
                mpie_d = 1'b1;
            end
            if (wr_en) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        if (!mret) begin
                            mie_d  = csr_wdata[MSTATUS_MIE];
                            mpie_d = csr_wdata[MSTATUS_MPIE];
                        end
                    end
                    CSR_MIE:      meie_d     = csr_wdata[MIE_MEIE];
                    CSR_MTVEC:    mtvec_d    = {csr_wdata[31:2], 2'b00};
                    CSR_MSCRATCH: mscratch_d = csr_wdata;
                    CSR_MEPC:     mepc_d     = {csr_wdata[31:2], 2'b00};
                    CSR_MCAUSE:   mcause_d   = csr_wdata;
                    default:      ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            meie_q     <= 1'b0;
            meip_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            meie_q     <= meie_d;
            meip_q     <= meip_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    assign irq_take    = mie_q && meie_q && meip_q;
    assign trap_vector = {mtvec_q[31:2], 2'b00};
    assign epc         = mepc_q;

endmodule
